// File: rtl/urv_iram_port_arbiter_if.sv
// Bus bundle for the uRV IRAM port-B arbiter: CPU and host requesters,
// error flag and the RAM port B connection.
interface urv_iram_port_arbiter_if;
    logic        cpu_req_i;
    logic        cpu_we_i;
    logic [31:0] cpu_addr_i;
    logic [3:0]  cpu_bwe_i;
    logic [31:0] cpu_data_i;
    logic        cpu_ack_o;
    logic [31:0] cpu_rdata_o;
    logic        cpu_rvalid_o;

    logic        host_req_i;
    logic        host_we_i;
    logic [31:0] host_addr_i;
    logic [3:0]  host_bwe_i;
    logic [31:0] host_data_i;
    logic        host_ack_o;
    logic [31:0] host_rdata_o;
    logic        host_rvalid_o;

    logic        err_o;

    logic        ram_en_o;
    logic        ram_we_o;
    logic [31:0] ram_addr_o;
    logic [3:0]  ram_bwe_o;
    logic [31:0] ram_data_o;
    logic [31:0] ram_q_i;

    modport slave (
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_bwe_i, cpu_data_i,
        output cpu_ack_o, cpu_rdata_o, cpu_rvalid_o,
        input  host_req_i, host_we_i, host_addr_i, host_bwe_i, host_data_i,
        output host_ack_o, host_rdata_o, host_rvalid_o,
        output err_o,
        output ram_en_o, ram_we_o, ram_addr_o, ram_bwe_o, ram_data_o,
        input  ram_q_i
    );

    modport master (
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_bwe_i, cpu_data_i,
        input  cpu_ack_o, cpu_rdata_o, cpu_rvalid_o,
        output host_req_i, host_we_i, host_addr_i, host_bwe_i, host_data_i,
        input  host_ack_o, host_rdata_o, host_rvalid_o,
        input  err_o,
        input  ram_en_o, ram_we_o, ram_addr_o, ram_bwe_o, ram_data_o,
        output ram_q_i
    );
endinterface

// File: rtl/urv_iram_port_arbiter.sv
// Arbitrates RAM port B between the CPU data bus and a host loader,
// registers the winner onto the RAM and routes read data back to its owner.
module urv_iram_port_arbiter #(
    parameter int unsigned g_size          = 65536,
    parameter bit          g_host_priority = 1'b0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    urv_iram_port_arbiter_if.slave  bus
);

    localparam int unsigned AW = $clog2(g_size);

    typedef struct packed {
        logic rd;
        logic host;
        logic inr;
    } tag_t;

    logic        last_host_q, last_host_d;
    logic        gnt_cpu, gnt_host, accept, issue;
    logic        sel_we, sel_inr;
    logic [31:0] sel_addr, sel_data;
    logic [3:0]  sel_bwe;

    logic        en_q, en_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  bwe_q, bwe_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;
    tag_t        tag0_q, tag0_d;
    tag_t        tag1_q;

    logic [31:0] ret_data;
    logic        cpu_rv, host_rv;
    logic [31:0] cpu_rdata_q, cpu_rdata_d;
    logic [31:0] host_rdata_q, host_rdata_d;

    // Grant is held off during reset so nothing is acked that would be lost.
    always_comb begin
        gnt_cpu  = 1'b0;
        gnt_host = 1'b0;
        if (!rst_i) begin
            if (bus.cpu_req_i && bus.host_req_i) begin
                if (g_host_priority || !last_host_q)
                    gnt_host = 1'b1;
                else
                    gnt_cpu = 1'b1;
            end else begin
                gnt_cpu  = bus.cpu_req_i;
                gnt_host = bus.host_req_i;
            end
        end
    end

    assign accept = gnt_cpu | gnt_host;

    always_comb begin
        sel_we   = bus.cpu_we_i;
        sel_addr = bus.cpu_addr_i;
        sel_bwe  = bus.cpu_bwe_i;
        sel_data = bus.cpu_data_i;
        if (gnt_host) begin
            sel_we   = bus.host_we_i;
            sel_addr = bus.host_addr_i;
            sel_bwe  = bus.host_bwe_i;
            sel_data = bus.host_data_i;
        end
    end

    assign sel_inr = ((sel_addr >> AW) == 32'd0);
    assign issue   = accept & sel_inr;

    always_comb begin
        last_host_d = accept ? gnt_host : last_host_q;
        en_d        = issue;
        we_d        = issue & sel_we;
        addr_d      = issue ? sel_addr : 32'd0;
        bwe_d       = (issue && sel_we) ? sel_bwe : 4'h0;
        data_d      = (issue && sel_we) ? sel_data : 32'd0;
        err_d       = accept & ~sel_inr;
        tag0_d.rd   = accept & ~sel_we;
        tag0_d.host = gnt_host;
        tag0_d.inr  = sel_inr;
    end

    // The RAM output is already registered, so read data is steered
    // straight through to the owner during the return cycle.
    assign ret_data = tag1_q.inr ? bus.ram_q_i : 32'd0;
    assign cpu_rv   = tag1_q.rd & ~tag1_q.host;
    assign host_rv  = tag1_q.rd & tag1_q.host;

    assign cpu_rdata_d  = cpu_rv ? ret_data : cpu_rdata_q;
    assign host_rdata_d = host_rv ? ret_data : host_rdata_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_host_q  <= 1'b1;
            en_q         <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= 32'd0;
            bwe_q        <= 4'h0;
            data_q       <= 32'd0;
            err_q        <= 1'b0;
            tag0_q       <= '0;
            tag1_q       <= '0;
            cpu_rdata_q  <= 32'd0;
            host_rdata_q <= 32'd0;
        end else begin
            last_host_q  <= last_host_d;
            en_q         <= en_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            bwe_q        <= bwe_d;
            data_q       <= data_d;
            err_q        <= err_d;
            tag0_q       <= tag0_d;
            tag1_q       <= tag0_q;
            cpu_rdata_q  <= cpu_rdata_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    assign bus.cpu_ack_o     = gnt_cpu;
    assign bus.host_ack_o    = gnt_host;
    assign bus.cpu_rvalid_o  = cpu_rv;
    assign bus.host_rvalid_o = host_rv;
    assign bus.cpu_rdata_o   = cpu_rdata_d;
    assign bus.host_rdata_o  = host_rdata_d;
    assign bus.err_o         = err_q;
    assign bus.ram_en_o      = en_q;
    assign bus.ram_we_o      = we_q;
    assign bus.ram_addr_o    = addr_q;
    assign bus.ram_bwe_o     = bwe_q;
    assign bus.ram_data_o    = data_q;

endmodule
